alu_md_ctrl: RTL
================

ALU_MD_CTRL -- requirements
Module: alu_md_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter ALUOP_W, default 3, width of alu_op from main control.
REQ-003 SHALL have parameter CTRL_W, default 4, width of alu_ctrl output.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  decode request present
  alu_op  in  ALUOP_W  instruction class from main control
  funct  in  6  instruction[5:0]
  src_a  in  DATA_W  rs operand (mult/div)
  src_b  in  DATA_W  rt operand (mult/div)
  flush  in  1  kill in-flight decode and mult/div
  alu_ctrl  out  CTRL_W  registered ALU operation code
  ctrl_valid  out  1  alu_ctrl valid this cycle
  illegal  out  1  registered unsupported alu_op/funct flag
  md_busy  out  1  mult/div in progress; pipeline stall
  md_done  out  1  one-cycle completion pulse
  hi  out  DATA_W  HI register
  lo  out  DATA_W  LO register

Function
REQ-006 SHALL register decode: in_valid accepted at edge t drives alu_ctrl/ctrl_valid/illegal at t+1 (latency 1).
REQ-007 alu_op map: 000 LW/SW->add 0010; 001 branch->sub 0110; 010 R-type->funct decode; 011 ori->or 0001; 100 xori->xor 0011; 101 slti->slt 0111; others->illegal.
REQ-008 funct map: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100110 xor 0011; 100111 nor 1100; 101010 slt 0111; 010000 mfhi/010010 mflo pass 1111; 011000 mult, 011001 multu, 011010 div, 011011 divu start mult/div, alu_ctrl 1111; others illegal.
REQ-009 Illegal decode SHALL set illegal=1, ctrl_valid=1, alu_ctrl=0010; no mult/div start.
REQ-010 FSM states IDLE, RUN, FIX; IDLE->RUN on accepted mult/div; RUN iterates DATA_W cycles (one bit/cycle, shift-add multiply, restoring divide); RUN->FIX; FIX->IDLE writing HI/LO.
REQ-011 Signed ops SHALL run on magnitudes; FIX applies signs: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-012 md_busy SHALL be high DATA_W+1 cycles from cycle after acceptance; md_done high in FIX cycle; new HI/LO visible first cycle md_busy low.
REQ-013 Mult: HI={upper DATA_W}, LO={lower DATA_W}; div: LO=quotient, HI=remainder.
REQ-014 Divide by zero SHALL complete normally with LO=all ones, HI=dividend (raw src_a).
REQ-015 While md_busy, in_valid SHALL be ignored (ctrl_valid=0); upstream holds instruction.
REQ-016 flush SHALL clear ctrl_valid/illegal next cycle; during RUN/FIX SHALL return FSM to IDLE next cycle, md_done=0, HI/LO unchanged.
REQ-017 flush and in_valid same cycle: flush wins, request dropped.
REQ-018 Operands SHALL be captured at acceptance; later src_a/src_b changes have no effect.

Reset
REQ-019 rst_n low SHALL asynchronously force FSM IDLE, alu_ctrl=0, ctrl_valid=0, illegal=0, md_busy=0, md_done=0, hi=0, lo=0.
REQ-020 Reset mid-operation SHALL abort with no HI/LO write; operation resumes only on new request after rst_n high.

Configuration
REQ-021 Macro ALU_MD_DIV_EN defined: div/divu supported per REQ-010..014.
REQ-022 Macro undefined: funct 011010/011011 decode illegal, no divider logic, mult unchanged.

Structure
REQ-023 Package alu_pkg SHALL hold ALU codes, funct codes, alu_op codes, FSM state typedef.
REQ-024 Iterative datapath SHALL be sub-module md_iter (operand/accumulator registers, per-cycle step, sign fixup); alu_md_ctrl holds decode and FSM.

Verification
REQ-025 R-type funct 100111 in_valid -> next cycle alu_ctrl=1100, ctrl_valid=1, illegal=0.
REQ-026 mult src_a=7, src_b=0xFFFFFFFD -> md_busy 33 cycles, md_done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-027 div src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2; divu 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-028 multu started, flush in 10th busy cycle -> md_busy low next cycle, no md_done, hi/lo unchanged.
REQ-029 rst_n low mid-div -> all outputs zero immediately; no HI/LO write after release.
REQ-030 ALU_MD_DIV_EN undefined, funct 011010 -> illegal=1, md_busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control / multiply-divide block: ALU codes,
// funct codes, alu_op classes and the mult/div sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [2:0] AOP_MEM   = 3'b000;
  localparam logic [2:0] AOP_BR    = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_ORI   = 3'b011;
  localparam logic [2:0] AOP_XORI  = 3'b100;
  localparam logic [2:0] AOP_SLTI  = 3'b101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_iter.sv
// One-bit-per-cycle multiply/divide datapath: magnitude capture, shift-add or
// restoring-divide step, and combinational sign fixup. Divide needs ALU_MD_DIV_EN.
module md_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_signed,
`ifdef ALU_MD_DIV_EN
  input  logic              is_div,
`endif
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam logic [DATA_W-1:0]   ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE2 = {{(2*DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   mcand_r, acc_hi_r, acc_lo_r;
  logic                neg_a_r, neg_b_r;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [2*DATA_W-1:0] prod_s;
`ifdef ALU_MD_DIV_EN
  logic                div_r;
  logic [DATA_W:0]     div_trial_s;
  logic [DATA_W-1:0]   quo_s, rem_s;
`endif

  // Operand magnitudes and per-step arithmetic
  always_comb begin
    a_mag_s   = (is_signed && src_a[DATA_W-1]) ? (~src_a + ONE) : src_a;
    b_mag_s   = (is_signed && src_b[DATA_W-1]) ? (~src_b + ONE) : src_b;
    mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}});
`ifdef ALU_MD_DIV_EN
    div_trial_s = {acc_hi_r, acc_lo_r[DATA_W-1]} - {1'b0, mcand_r};
`endif
  end

  // Operand capture on load, one iteration per step; acc_lo holds multiplier or dividend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {DATA_W{1'b0}};
      acc_hi_r <= {DATA_W{1'b0}};
      acc_lo_r <= {DATA_W{1'b0}};
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
`ifdef ALU_MD_DIV_EN
      div_r    <= 1'b0;
`endif
    end else if (load) begin
      mcand_r  <= b_mag_s;
      acc_hi_r <= {DATA_W{1'b0}};
      acc_lo_r <= a_mag_s;
      neg_a_r  <= is_signed & src_a[DATA_W-1];
      neg_b_r  <= is_signed & src_b[DATA_W-1];
`ifdef ALU_MD_DIV_EN
      div_r    <= is_div;
`endif
    end else if (step) begin
`ifdef ALU_MD_DIV_EN
      if (div_r) begin
        if (div_trial_s[DATA_W]) begin
          acc_hi_r <= {acc_hi_r[DATA_W-2:0], acc_lo_r[DATA_W-1]};
          acc_lo_r <= {acc_lo_r[DATA_W-2:0], 1'b0};
        end else begin
          acc_hi_r <= div_trial_s[DATA_W-1:0];
          acc_lo_r <= {acc_lo_r[DATA_W-2:0], 1'b1};
        end
      end else begin
        acc_hi_r <= mul_sum_s[DATA_W:1];
        acc_lo_r <= {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
      end
`else
      acc_hi_r <= mul_sum_s[DATA_W:1];
      acc_lo_r <= {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
`endif
    end
  end

  // Sign fixup; a zero divisor forces an all-ones quotient, remainder is then the dividend
  always_comb begin
    if (neg_a_r ^ neg_b_r) begin
      prod_s = ~{acc_hi_r, acc_lo_r} + ONE2;
    end else begin
      prod_s = {acc_hi_r, acc_lo_r};
    end
`ifdef ALU_MD_DIV_EN
    if (mcand_r == {DATA_W{1'b0}}) begin
      quo_s = {DATA_W{1'b1}};
    end else if (neg_a_r ^ neg_b_r) begin
      quo_s = ~acc_lo_r + ONE;
    end else begin
      quo_s = acc_lo_r;
    end
    if (neg_a_r) begin
      rem_s = ~acc_hi_r + ONE;
    end else begin
      rem_s = acc_hi_r;
    end
    if (div_r) begin
      res_hi = rem_s;
      res_lo = quo_s;
    end else begin
      res_hi = prod_s[2*DATA_W-1:DATA_W];
      res_lo = prod_s[DATA_W-1:0];
    end
`else
    res_hi = prod_s[2*DATA_W-1:DATA_W];
    res_lo = prod_s[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/alu_md_ctrl.sv
// ALU control decode with an iterative HI/LO multiply/divide sequencer.
// Divide support is compiled in only when ALU_MD_DIV_EN is defined.
module alu_md_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic               flush,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               ctrl_valid,
  output logic               illegal,
  output logic               md_busy,
  output logic               md_done,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [CTRL_W-1:0] alu_ctrl_r;
  logic              ctrl_valid_r, illegal_r, md_busy_r, md_done_r;
  logic [DATA_W-1:0] hi_r, lo_r, md_hi_s, md_lo_s;
  logic [3:0]        dec_ctrl_s;
  logic              dec_illegal_s, dec_md_start_s, dec_md_signed_s;
  logic              accept_s, md_load_s, md_step_s, hilo_we_s;
`ifdef ALU_MD_DIV_EN
  logic              dec_md_div_s;
`endif

  // Requests are taken only while idle; flush wins over a same-cycle request
  assign accept_s = in_valid && !flush && (state_r == MD_IDLE);

  // Instruction class / funct decode
  always_comb begin
    dec_ctrl_s      = ALU_ADD;
    dec_illegal_s   = 1'b0;
    dec_md_start_s  = 1'b0;
    dec_md_signed_s = 1'b0;
`ifdef ALU_MD_DIV_EN
    dec_md_div_s    = 1'b0;
`endif
    case (alu_op)
      ALUOP_W'(AOP_MEM):  dec_ctrl_s = ALU_ADD;
      ALUOP_W'(AOP_BR):   dec_ctrl_s = ALU_SUB;
      ALUOP_W'(AOP_ORI):  dec_ctrl_s = ALU_OR;
      ALUOP_W'(AOP_XORI): dec_ctrl_s = ALU_XOR;
      ALUOP_W'(AOP_SLTI): dec_ctrl_s = ALU_SLT;
      ALUOP_W'(AOP_RTYPE): begin
        case (funct)
          FN_ADD:           dec_ctrl_s = ALU_ADD;
          FN_SUB:           dec_ctrl_s = ALU_SUB;
          FN_AND:           dec_ctrl_s = ALU_AND;
          FN_OR:            dec_ctrl_s = ALU_OR;
          FN_XOR:           dec_ctrl_s = ALU_XOR;
          FN_NOR:           dec_ctrl_s = ALU_NOR;
          FN_SLT:           dec_ctrl_s = ALU_SLT;
          FN_MFHI, FN_MFLO: dec_ctrl_s = ALU_PASS;
          FN_MULT: begin
            dec_ctrl_s      = ALU_PASS;
            dec_md_start_s  = 1'b1;
            dec_md_signed_s = 1'b1;
          end
          FN_MULTU: begin
            dec_ctrl_s     = ALU_PASS;
            dec_md_start_s = 1'b1;
          end
`ifdef ALU_MD_DIV_EN
          FN_DIV: begin
            dec_ctrl_s      = ALU_PASS;
            dec_md_start_s  = 1'b1;
            dec_md_signed_s = 1'b1;
            dec_md_div_s    = 1'b1;
          end
          FN_DIVU: begin
            dec_ctrl_s     = ALU_PASS;
            dec_md_start_s = 1'b1;
            dec_md_div_s   = 1'b1;
          end
`endif
          default: dec_illegal_s = 1'b1;
        endcase
      end
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // Decode output registers; illegal decodes never start the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_r   <= {CTRL_W{1'b0}};
      ctrl_valid_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      ctrl_valid_r <= accept_s;
      illegal_r    <= accept_s & dec_illegal_s;
      if (accept_s) begin
        alu_ctrl_r <= CTRL_W'(dec_ctrl_s);
      end
    end
  end

  // Sequencer next state: DATA_W RUN steps then one FIX cycle that commits HI/LO
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    md_load_s    = 1'b0;
    md_step_s    = 1'b0;
    hilo_we_s    = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (accept_s && dec_md_start_s && !dec_illegal_s) begin
          state_next_s = MD_RUN;
          cnt_next_s   = {CNT_W{1'b0}};
          md_load_s    = 1'b1;
        end else begin
          state_next_s = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_next_s = MD_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          md_step_s    = 1'b1;
          state_next_s = MD_FIX;
        end else begin
          md_step_s  = 1'b1;
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      MD_FIX: begin
        state_next_s = MD_IDLE;
        if (flush) begin
          hilo_we_s = 1'b0;
        end else begin
          hilo_we_s = 1'b1;
        end
      end
      default: state_next_s = MD_IDLE;
    endcase
  end

  // Sequencer state, status flags and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= MD_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      md_busy_r <= 1'b0;
      md_done_r <= 1'b0;
      hi_r      <= {DATA_W{1'b0}};
      lo_r      <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      md_busy_r <= (state_next_s != MD_IDLE);
      md_done_r <= (state_next_s == MD_FIX);
      if (hilo_we_s) begin
        hi_r <= md_hi_s;
        lo_r <= md_lo_s;
      end
    end
  end

  md_iter #(.DATA_W(DATA_W)) u_md_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (md_load_s),
    .step      (md_step_s),
    .is_signed (dec_md_signed_s),
`ifdef ALU_MD_DIV_EN
    .is_div    (dec_md_div_s),
`endif
    .src_a     (src_a),
    .src_b     (src_b),
    .res_hi    (md_hi_s),
    .res_lo    (md_lo_s)
  );

  assign alu_ctrl   = alu_ctrl_r;
  assign ctrl_valid = ctrl_valid_r;
  assign illegal    = illegal_r;
  assign md_busy    = md_busy_r;
  assign md_done    = md_done_r;
  assign hi         = hi_r;
  assign lo         = lo_r;

endmodule
